data_memory_bytelane: RTL and testbench
=======================================

// Module: data_memory_bytelane
// PURPOSE
//  Parametrised, clocked data memory for the MEM stage of the pipelined core.
//  Byte-addressed, little-endian, with byte/half/word loads (sign- or zero-extended) and stores.
//  Loads have registered one-cycle latency, and misaligned or out-of-range accesses raise a fault.
//  A post-reset clear FSM zeroes the array, replacing the old initial-block fill.
// PARAMETERS
//  DEPTH_WORDS     128  number of 32-bit words; power of two, >= 2
//  ADDR_W          32   width of the byte address port
//  CLEAR_ON_RESET  1    1: zero the whole array after reset; 0: skip the clear and go straight to IDLE
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  ready        out  1       1 = requests are accepted this cycle
//  req_valid    in   1       request present
//  req_we       in   1       1 = store, 0 = load
//  req_size     in   2       00 = byte, 01 = half, 10 = word, 11 = reserved
//  req_unsigned in   1       loads only: 1 = zero-extend, 0 = sign-extend
//  addr         in   ADDR_W  byte address
//  wdata        in   32      store data, right-justified (byte uses [7:0], half uses [15:0])
//  rdata        out  32      load result, valid when rvalid = 1
//  rvalid       out  1       one-cycle pulse per accepted, non-faulting load
//  fault        out  1       one-cycle pulse per accepted request that is misaligned, out-of-range or reserved
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - ready = 0, rvalid = 0, fault = 0, rdata = 0, state = CLEAR, clear_ptr = 0.
//   - The array itself is not touched asynchronously.
//  FSM states: CLEAR -> IDLE
//   - CLEAR: writes 0 to mem[clear_ptr] each cycle and increments clear_ptr.
//     - After writing word DEPTH_WORDS-1, moves to IDLE; ready = 1 from the next cycle.
//     - Total: DEPTH_WORDS cycles from reset release to ready.
//   - CLEAR_ON_RESET = 0: the first clock after reset release goes to IDLE.
//   - Reset asserted mid-CLEAR: clear_ptr restarts at 0.
//  Acceptance
//   - A request is accepted on a rising edge with ready & req_valid.
//   - While ready = 0, requests are ignored: no write, no rvalid, no fault.
//   - At most one request per cycle; no back-pressure in IDLE.
//  Fault conditions, evaluated at acceptance
//   - req_size = 11.
//   - Half access with addr[0] = 1.
//   - Word access with addr[1:0] != 0.
//   - addr >= 4*DEPTH_WORDS.
//   - On fault: store is suppressed, load gives no rvalid.
//   - fault = 1 for exactly the cycle after acceptance; rdata keeps its previous value.
//  Store, accepted at edge N
//   - Byte enables are generated from req_size and addr[1:0].
//   - Data is replicated into the addressed lane(s).
//   - Only enabled bytes of mem[addr[2 +: log2(DEPTH_WORDS)]] change, at edge N.
//  Load, accepted at edge N
//   - The word is read and the lane is extracted via addr[1:0].
//   - The result is sign- or zero-extended to 32 bits.
//   - rdata is registered at edge N; rvalid = 1 during cycle N+1 only.
//   - rdata holds its value until the next non-faulting load.
//  Ordering
//   - A load accepted one cycle after a store to the same word returns the post-store data.
//   - No forwarding is needed, because the write completes at the earlier edge.
//  Reserved encodings: req_unsigned is ignored for stores and for word loads.
// STRUCTURE
//  Shared header dmem_defs.vh:
//   - SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD encodings.
//   - ST_CLEAR / ST_IDLE state codes.
//  Sub-module dmem_lane_align (combinational):
//   - Inputs: size, addr[1:0], unsigned, wdata, raw word.
//   - Outputs: byte_en[3:0], aligned store word, extended load result, misalign flag.
//  Top level holds the array, the clear FSM/counter, range check and output registers.
// TESTING
//  - Reset then wait: ready = 0 for 128 cycles, 1 on cycle 129.
//    - Word loads of addr 0x000 and 0x1FC return 0x00000000.
//  - sw 0x80FF7F01 @0x10; then lb / lbu / lh / lhu @0x10-0x13:
//    - lb @0x10 = 0x00000001; lb @0x11 = 0x0000007F; lb @0x12 = 0xFFFFFFFF; lbu @0x13 = 0x00000080.
//    - lh @0x12 = 0xFFFF80FF; lhu @0x12 = 0x000080FF.
//  - sb 0xAB @0x21 over word 0x11223344 @0x20:
//    - Next-cycle lw @0x20 = 0x1122AB44, with rvalid high exactly one cycle.
//  - Faults:
//    - lw @0x22, sh 0x1234 @0x21, lw @0x200, size = 11: each gives a one-cycle fault and no rvalid.
//    - Memory at 0x20 is unchanged.
//  - Reset during CLEAR and during a load:
//    - Outputs drop to 0 immediately.
//    - The clear restarts and ready returns after exactly DEPTH_WORDS cycles.
//  - Requests with req_valid = 1 while ready = 0 cause no write, no rvalid and no fault.
//    - Repeat the sweep with CLEAR_ON_RESET = 0: ready = 1 one cycle after release.

Source files
------------

// File: rtl/data_memory_bytelane_pkg.sv
// Shared encodings and lane-extension helpers for the byte-lane data memory.
package data_memory_bytelane_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic is_unsigned);
        return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic is_unsigned);
        return is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/data_memory_bytelane_lane_align.sv
// Combinational lane steering: byte enables, store replication, load extraction
// with sign/zero extension, and half/word misalignment detection.
module data_memory_bytelane_lane_align
    import data_memory_bytelane_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    always_comb begin
        byte_en    = '0;
        store_word = '0;
        load_data  = '0;
        misalign   = 1'b0;
        case (size_e'(size))
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{wdata[7:0]}};
                load_data  = ext8(raw_word[{addr_lo, 3'b000} +: 8], is_unsigned);
            end
            SZ_HALF: begin
                misalign   = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata[15:0]}};
                load_data  = ext16(addr_lo[1] ? raw_word[31:16] : raw_word[15:0], is_unsigned);
            end
            SZ_WORD: begin
                misalign   = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
                store_word = wdata;
                load_data  = raw_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// MEM-stage data memory: byte-addressed little-endian array with registered loads,
// fault reporting, and a post-reset clear sweep that zeroes every word.
module data_memory_bytelane
    import data_memory_bytelane_pkg::*;
#(
    parameter int DEPTH_WORDS    = 128,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

    state_e           state;
    logic [IDX_W-1:0] clear_ptr;
    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic             accept;
    logic             out_of_range;
    logic             misalign;
    logic             bad_req;
    logic             clearing;
    logic [3:0]       byte_en;
    logic [31:0]      store_word;
    logic [31:0]      load_data;
    logic [31:0]      raw_word;

    assign word_idx     = addr[IDX_W+1:2];
    assign accept       = ready && req_valid;
    assign out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
    assign bad_req      = (req_size == SZ_RSVD) || misalign || out_of_range;
    assign raw_word     = mem[word_idx];
    assign clearing     = (state == ST_CLEAR) && CLEAR_ON_RESET;

    data_memory_bytelane_lane_align u_align (
        .size        (req_size),
        .addr_lo     (addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (wdata),
        .raw_word    (raw_word),
        .byte_en     (byte_en),
        .store_word  (store_word),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    // The array has no reset; it is zeroed by the clear sweep instead.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clear_ptr] <= '0;
        end else if (accept && req_we && !bad_req) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
            ready     <= 1'b0;
            rvalid    <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
        end else begin
            rvalid <= 1'b0;
            fault  <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (!CLEAR_ON_RESET || clear_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else begin
                        clear_ptr <= clear_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (bad_req) begin
                            fault <= 1'b1;
                        end else if (!req_we) begin
                            rvalid <= 1'b1;
                            rdata  <= load_data;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Scoreboard bench: a byte-array reference model predicts every cycle's outputs,
// which are queued at drive time and compared once the DUT has responded.
module tb_data_memory_bytelane;

    localparam int DEPTH = 128;
    localparam int BYTES = 4 * DEPTH;

    logic        clk;
    logic        rst_n;
    logic        rst0_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready, rvalid, fault;
    logic [31:0] rdata;
    logic        ready0, rvalid0, fault0;
    logic [31:0] rdata0;

    typedef struct {
        string       tag;
        logic        rvalid;
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model_bytes [BYTES];
    bit          model_ready;
    int          model_cnt;
    logic [31:0] model_rdata;
    int          checks = 0;
    int          errors = 0;

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .fault(fault)
    );

    data_memory_bytelane #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .ready(ready0), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .rvalid(rvalid0), .fault(fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic bit modelFault(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'b11) || (size == 2'b01 && a[0]) ||
               (size == 2'b10 && a[1:0] != 2'b00) || (a >= 32'(BYTES));
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input bit uns, input logic [31:0] a);
        int i = int'(a[8:0]);
        logic [31:0] v;
        case (size)
            2'b00:   v = uns ? {24'b0, model_bytes[i]} : {{24{model_bytes[i][7]}}, model_bytes[i]};
            2'b01:   v = uns ? {16'b0, model_bytes[i+1], model_bytes[i]}
                             : {{16{model_bytes[i+1][7]}}, model_bytes[i+1], model_bytes[i]};
            default: v = {model_bytes[i+3], model_bytes[i+2], model_bytes[i+1], model_bytes[i]};
        endcase
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
        int i = int'(a[8:0]);
        model_bytes[i] = wd[7:0];
        if (size != 2'b00) model_bytes[i+1] = wd[15:8];
        if (size == 2'b10) begin
            model_bytes[i+2] = wd[23:16];
            model_bytes[i+3] = wd[31:24];
        end
    endtask

    // One request cycle: predict, drive, then compare after the active edge.
    task automatic applyStimulus(input bit valid, input bit we, input logic [1:0] size, input bit uns,
                                 input logic [31:0] a, input logic [31:0] wd, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        req_valid = valid; req_we = we; req_size = size; req_unsigned = uns; addr = a; wdata = wd;
        e.tag = tag; e.rvalid = 1'b0; e.fault = 1'b0;
        if (valid && model_ready) begin
            if (modelFault(size, a)) e.fault = 1'b1;
            else if (we) modelStore(size, a, wd);
            else begin
                e.rvalid = 1'b1;
                model_rdata = modelLoad(size, uns, a);
            end
        end
        e.rdata = model_rdata;
        sb.push_back(e);
        @(posedge clk);
        if (!model_ready) begin
            if (model_cnt == DEPTH - 1) model_ready = 1'b1;
            model_cnt++;
        end
        #1;
        req_valid = 1'b0;
        got = sb.pop_front();
        checkOutput({got.tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, got.rvalid});
        checkOutput({got.tag, ".fault"}, {31'b0, fault}, {31'b0, got.fault});
        checkOutput({got.tag, ".rdata"}, rdata, got.rdata);
        checkOutput({got.tag, ".ready"}, {31'b0, ready}, {31'b0, model_ready});
    endtask

    task automatic resetDut(input string tag);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, ".ready"}, {31'b0, ready}, 32'd0);
        checkOutput({tag, ".rvalid"}, {31'b0, rvalid}, 32'd0);
        checkOutput({tag, ".fault"}, {31'b0, fault}, 32'd0);
        checkOutput({tag, ".rdata"}, rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ready = 1'b0;
        model_cnt = 0;
        model_rdata = '0;
        for (int i = 0; i < BYTES; i++) model_bytes[i] = 8'h00;
        sb.delete();
    endtask

    task automatic waitClearWithIgnoredRequests();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, (i % 2) == 0, (i % 3 == 0) ? 2'b11 : 2'b10, 1'b0,
                          (i % 5 == 0) ? 32'h200 : 32'h0, 32'hDEADBEEF, "ignored");
        end
    endtask

    initial begin
        rst_n = 1'b0; rst0_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        addr = '0; wdata = '0;

        resetDut("reset0");
        waitClearWithIgnoredRequests();
        applyStimulus(1, 0, 2'b10, 0, 32'h000, 0, "lw_0x000");
        applyStimulus(1, 0, 2'b10, 0, 32'h1FC, 0, "lw_0x1FC");
        applyStimulus(1, 0, 2'b00, 1, 32'h1FF, 0, "lbu_0x1FF");

        applyStimulus(1, 1, 2'b10, 0, 32'h10, 32'h80FF7F01, "sw_0x10");
        applyStimulus(1, 0, 2'b00, 0, 32'h10, 0, "lb_0x10");
        applyStimulus(1, 0, 2'b00, 0, 32'h11, 0, "lb_0x11");
        applyStimulus(1, 0, 2'b00, 0, 32'h12, 0, "lb_0x12");
        applyStimulus(1, 0, 2'b00, 1, 32'h13, 0, "lbu_0x13");
        applyStimulus(1, 0, 2'b00, 0, 32'h13, 0, "lb_0x13");
        applyStimulus(1, 0, 2'b01, 0, 32'h12, 0, "lh_0x12");
        applyStimulus(1, 0, 2'b01, 1, 32'h12, 0, "lhu_0x12");
        applyStimulus(1, 0, 2'b01, 0, 32'h10, 0, "lh_0x10");
        applyStimulus(1, 0, 2'b10, 1, 32'h10, 0, "lw_uns_0x10");

        applyStimulus(1, 1, 2'b10, 0, 32'h20, 32'h11223344, "sw_0x20");
        applyStimulus(1, 1, 2'b00, 0, 32'h21, 32'hFFFFFFAB, "sb_0x21");
        applyStimulus(1, 0, 2'b10, 0, 32'h20, 0, "lw_0x20");
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 0, "idle_after_lw");

        applyStimulus(1, 0, 2'b10, 0, 32'h22, 0, "flt_lw_0x22");
        applyStimulus(1, 1, 2'b01, 0, 32'h21, 32'h1234, "flt_sh_0x21");
        applyStimulus(1, 0, 2'b10, 0, 32'h200, 0, "flt_lw_0x200");
        applyStimulus(1, 1, 2'b10, 0, 32'h200, 32'h55555555, "flt_sw_0x200");
        applyStimulus(1, 0, 2'b11, 0, 32'h20, 0, "flt_rsvd_ld");
        applyStimulus(1, 1, 2'b11, 0, 32'h20, 32'h99999999, "flt_rsvd_st");
        applyStimulus(1, 0, 2'b10, 0, 32'h20, 0, "lw_0x20_after_faults");
        applyStimulus(1, 1, 2'b01, 0, 32'h26, 32'hCAFE8001, "sh_0x26");
        applyStimulus(1, 0, 2'b01, 0, 32'h26, 0, "lh_0x26");
        applyStimulus(1, 0, 2'b10, 0, 32'h24, 0, "lw_0x24");

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h23F)), $urandom, "rand");
        end

        applyStimulus(1, 0, 2'b10, 0, 32'h20, 0, "lw_before_reset");
        resetDut("reset_during_load");
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 2'b00, 0, 32'h0, 0, "partial_clear");
        resetDut("reset_during_clear");
        waitClearWithIgnoredRequests();
        applyStimulus(1, 0, 2'b10, 0, 32'h10, 0, "lw_0x10_recleared");
        applyStimulus(1, 0, 2'b10, 0, 32'h20, 0, "lw_0x20_recleared");

        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("nc_reset.ready", {31'b0, ready0}, 32'd0);
        checkOutput("nc_reset.rdata", rdata0, 32'd0);
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; addr = 32'h4;
        @(posedge clk);
        #1;
        checkOutput("nc_first.ready", {31'b0, ready0}, 32'd1);
        checkOutput("nc_first.fault", {31'b0, fault0}, 32'd0);
        checkOutput("nc_first.rvalid", {31'b0, rvalid0}, 32'd0);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; addr = 32'h4; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        checkOutput("nc_sw.fault", {31'b0, fault0}, 32'd0);
        checkOutput("nc_sw.rvalid", {31'b0, rvalid0}, 32'd0);
        @(negedge clk);
        req_we = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("nc_lw.rvalid", {31'b0, rvalid0}, 32'd1);
        checkOutput("nc_lw.rdata", rdata0, 32'h12345678);
        @(negedge clk);
        addr = 32'h6;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("nc_flt.fault", {31'b0, fault0}, 32'd1);
        checkOutput("nc_flt.rvalid", {31'b0, rvalid0}, 32'd0);
        checkOutput("nc_flt.rdata", rdata0, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
